program_memory_banked: RTL and testbench
========================================

Name: program_memory_banked

Overview:
- Parametrised, writable successor to the fixed four-program instruction memory.
- Holds NUM_BANKS program banks of BANK_DEPTH words each, with a registered fetch port toward the control unit.
- Provides a valid/ready loader port, plus a bank-clear engine, so programs are written at run time rather than hard-coded.
- Program selection is priority-encoded (lowest set bit wins), but latched only on request, so switches cannot change the active program mid-execution.

Parameters:
- DATA_WIDTH, 16: instruction word width.
- ADDR_WIDTH, 8: fetch/load address width.
- BANK_DEPTH, 128: words per bank; must be ≤ 2**ADDR_WIDTH.
- NUM_BANKS, 4: number of program banks; must be ≤ SEL_WIDTH.
- SEL_WIDTH, 8: width of the programSelect switch vector.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- programSelect  in  SEL_WIDTH  one bit per program switch.
- selLatch  in  1  pulse: capture programSelect into the active bank.
- activeBank  out  $clog2(NUM_BANKS)  currently latched bank.
- bankValid  out  1  latched selection names an existing bank.
- fetchEn  in  1  fetch request.
- address  in  ADDR_WIDTH  fetch address.
- instruction  out  DATA_WIDTH  fetched word, registered.
- instrValid  out  1  instruction holds the result of the previous cycle's fetch.
- loadValid  in  1  loader write request.
- loadReady  out  1  loader write accepted this cycle.
- loadBank  in  $clog2(NUM_BANKS)  target bank.
- loadAddr  in  ADDR_WIDTH  target word.
- loadData  in  DATA_WIDTH  word to write.
- loadErr  out  1  one-cycle pulse: accepted write had loadAddr ≥ BANK_DEPTH; the write is dropped.
- clearReq  in  1  start clearing clearBank.
- clearBank  in  $clog2(NUM_BANKS)  bank to clear.
- clearBusy  out  1  clear engine running.
- clearDone  out  1  one-cycle pulse at clear completion.

Behaviour:
- Reset state:
  - All outputs 0: instruction, instrValid, activeBank, bankValid, loadErr, clearBusy, clearDone.
  - FSM goes to IDLE; clear counter goes to 0.
  - Memory contents are NOT reset; loadReady is low while rst_n is low.
- Selection:
  - On a selLatch cycle, the next edge sets activeBank to the index of the lowest set bit of programSelect.
  - bankValid=1 only if some bit is set and that index < NUM_BANKS; otherwise bankValid=0 and activeBank holds its old value.
  - A fetch in the same cycle as selLatch uses the old bank.
- Fetch, one-cycle latency:
  - On a fetchEn cycle, the next edge loads instruction with mem[activeBank][address] and sets instrValid=1.
  - instruction is forced to 0 when bankValid=0 or address ≥ BANK_DEPTH.
  - Without fetchEn, instrValid=0 and instruction holds its value.
- FSM has two states: IDLE and CLEAR.
- IDLE:
  - loadReady = ~clearReq; clear has priority over load.
  - A load handshake (loadValid & loadReady) writes the word at the next edge.
  - clearReq moves to CLEAR, latches clearBank and sets counter=0.
- CLEAR:
  - Each cycle writes 0 to mem[bank][counter] and increments counter; clearBusy=1, loadReady=0.
  - After writing BANK_DEPTH-1 it returns to IDLE with a clearDone pulse, so a clear lasts exactly BANK_DEPTH cycles.
  - clearReq is ignored while busy.
- Read/write collision:
  - A fetch and a write (load or clear) to the same word in the same cycle returns the OLD data (read-first).
  - A fetch from a bank being cleared returns its partially cleared contents; there is no stall.
- Reset mid-clear: abort to IDLE; already-cleared words stay 0 and the rest are untouched.

Optional Feature:
- Macro: PROGMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from loadData on write; cleared words store parity 0.
  - Fetch recomputes parity and drives an extra port, parityErr (out, 1), registered alongside instruction and reset to 0.
  - On a mismatch, instruction is forced to 0 (a NOP/set).
- Not defined: no parity storage and no parityErr port.

Decomposition:
- Shared package progmem_pkg holds:
  - default width/depth constants.
  - The FSM state enum {IDLE, CLEAR}.
  - The HALT opcode constant 4'b1110 used by benches.
- Natural sub-module: lowest_set_encoder, a parametrised priority encoder returning index plus found flag, so it can be reused for the register-file select.

Test Plan:
- Load banks 0–1 with 0x1100,0x0201,0xE000; programSelect=8'b0000_0011, pulse selLatch; fetch addr 0..2 → 0x1100,0x0201,0xE000 from bank 0, each one cycle after fetchEn.
- programSelect=8'b0001_0000 with NUM_BANKS=4, selLatch → bankValid=0, fetch returns 0x0000; programSelect=0 → same.
- Change programSelect without selLatch mid-fetch stream → activeBank unchanged, instructions unchanged.
- clearReq bank 1 → clearBusy for exactly 128 cycles, clearDone once, loadReady=0 throughout; fetch bank 1 afterwards → all 0x0000.
- Same cycle: load 0x4332 to bank0 addr3 and fetch bank0 addr3 → old word returned; next fetch → 0x4332. clearReq together with loadValid → loadReady=0, load retried after clear.
- loadAddr=200 → loadErr pulse, memory unchanged. rst_n low at clear cycle 50 → outputs 0, words 0–49 zero, word 50+ intact.

Source files
------------

// File: rtl/progmem_pkg.sv
// Shared constants and types for the banked program memory and its benches.
// Default geometry, controller state encoding and the HALT opcode.
package progmem_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_BANK_DEPTH = 128;
  localparam int DEF_NUM_BANKS  = 4;
  localparam int DEF_SEL_WIDTH  = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } progmemState_t;

  localparam logic [3:0] HALT_OPCODE = 4'b1110;

endpackage

// File: rtl/lowest_set_encoder.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set bit and a found flag.
// Combinational, zero latency; no handshake, so there is no backpressure.
module lowest_set_encoder #(
  parameter int WIDTH = 8,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IW-1:0]    index,
  output logic             found
);

  // Scan downward so the last hit, the lowest index, wins.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        index = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/program_memory_banked.sv
// Banked writable program memory: registered fetch (1 cycle), loader port, bank-clear engine.
// loadReady drops during clearReq/clear and in reset; optional parity via PROGMEM_PARITY_EN.
module program_memory_banked
  import progmem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BANK_DEPTH = DEF_BANK_DEPTH,
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int SEL_WIDTH  = DEF_SEL_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SEL_WIDTH-1:0]         programSelect,
  input  logic                         selLatch,
  output logic [$clog2(NUM_BANKS)-1:0] activeBank,
  output logic                         bankValid,
  input  logic                         fetchEn,
  input  logic [ADDR_WIDTH-1:0]        address,
  output logic [DATA_WIDTH-1:0]        instruction,
  output logic                         instrValid,
  input  logic                         loadValid,
  output logic                         loadReady,
  input  logic [$clog2(NUM_BANKS)-1:0] loadBank,
  input  logic [ADDR_WIDTH-1:0]        loadAddr,
  input  logic [DATA_WIDTH-1:0]        loadData,
  output logic                         loadErr,
  input  logic                         clearReq,
  input  logic [$clog2(NUM_BANKS)-1:0] clearBank,
  output logic                         clearBusy,
  output logic                         clearDone
`ifdef PROGMEM_PARITY_EN
  ,
  output logic                         parityErr
`endif
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam int CW = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int MW = $clog2(NUM_BANKS * BANK_DEPTH);
  localparam int IW = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 1;
`ifdef PROGMEM_PARITY_EN
  localparam int WW = DATA_WIDTH + 1;
`else
  localparam int WW = DATA_WIDTH;
`endif

  logic [WW-1:0]  mem [NUM_BANKS * BANK_DEPTH];

  progmemState_t  state;
  logic [CW-1:0]  clrCnt;
  logic [BW-1:0]  clrBank;

  logic [IW-1:0]  encIndex;
  logic           encFound;
  logic           selHit;

  logic           fetchInRange;
  logic           fetchOk;
  logic [MW-1:0]  rdIdx;
  logic [WW-1:0]  rdWord;

  logic           loadFire;
  logic           loadAddrOk;
  logic           loadBankOk;

  logic           wrEn;
  logic [MW-1:0]  wrIdx;
  logic [WW-1:0]  wrWord;

  // Program selection: only captured on selLatch so switches cannot retarget a running program.
  lowest_set_encoder #(
    .WIDTH (SEL_WIDTH)
  ) uSelEnc (
    .vec   (programSelect),
    .index (encIndex),
    .found (encFound)
  );

  assign selHit = encFound && (32'(encIndex) < NUM_BANKS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      activeBank <= '0;
      bankValid  <= 1'b0;
    end else if (selLatch) begin
      bankValid <= selHit;
      if (selHit) begin
        activeBank <= BW'(encIndex);
      end
    end
  end

  // Fetch path
  assign fetchInRange = 32'(address) < BANK_DEPTH;
  assign rdIdx        = MW'(activeBank) * MW'(BANK_DEPTH) + MW'(address);
  assign rdWord       = mem[rdIdx];

`ifdef PROGMEM_PARITY_EN
  logic rdParityBad;
  assign rdParityBad = ^rdWord;
  assign fetchOk     = bankValid && fetchInRange && !rdParityBad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parityErr <= 1'b0;
    end else begin
      parityErr <= fetchEn && bankValid && fetchInRange && rdParityBad;
    end
  end
`else
  assign fetchOk = bankValid && fetchInRange;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= '0;
      instrValid  <= 1'b0;
    end else begin
      instrValid <= fetchEn;
      if (fetchEn) begin
        instruction <= fetchOk ? rdWord[DATA_WIDTH-1:0] : '0;
      end
    end
  end

  // Loader handshake: a pending clearReq steals the write port, so the loader must wait.
  assign loadReady  = rst_n && (state == IDLE) && !clearReq;
  assign loadFire   = loadValid && loadReady;
  assign loadAddrOk = 32'(loadAddr) < BANK_DEPTH;
  assign loadBankOk = 32'(loadBank) < NUM_BANKS;
  assign clearBusy  = (state == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clrCnt    <= '0;
      clrBank   <= '0;
      clearDone <= 1'b0;
      loadErr   <= 1'b0;
    end else begin
      clearDone <= 1'b0;
      loadErr   <= 1'b0;
      case (state)
        IDLE: begin
          if (clearReq) begin
            state   <= CLEAR;
            clrBank <= clearBank;
            clrCnt  <= '0;
          end else if (loadFire) begin
            loadErr <= !loadAddrOk;
          end
        end
        CLEAR: begin
          if (clrCnt == CW'(BANK_DEPTH - 1)) begin
            state     <= IDLE;
            clrCnt    <= '0;
            clearDone <= 1'b1;
          end else begin
            clrCnt <= clrCnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single write port shared by the clear engine and the loader.
  always_comb begin
    wrEn   = 1'b0;
    wrIdx  = '0;
    wrWord = '0;
    if (state == CLEAR) begin
      wrEn  = 1'b1;
      wrIdx = MW'(clrBank) * MW'(BANK_DEPTH) + MW'(clrCnt);
    end else if (loadFire && loadAddrOk && loadBankOk) begin
      wrEn  = 1'b1;
      wrIdx = MW'(loadBank) * MW'(BANK_DEPTH) + MW'(loadAddr);
`ifdef PROGMEM_PARITY_EN
      wrWord = {^loadData, loadData};
`else
      wrWord = loadData;
`endif
    end
  end

  // Storage has no reset; a non-blocking write gives read-first behaviour against same-cycle fetches.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrIdx] <= wrWord;
    end
  end

endmodule

// File: tb/tb_program_memory_banked.sv
// Randomized scoreboard bench for program_memory_banked against an array-based reference model.
module tb_program_memory_banked;
  import progmem_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int BD = 128;
  localparam int NB = 4;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] programSelect;
  logic          selLatch;
  logic [1:0]    activeBank;
  logic          bankValid;
  logic          fetchEn;
  logic [AW-1:0] address;
  logic [DW-1:0] instruction;
  logic          instrValid;
  logic          loadValid;
  logic          loadReady;
  logic [1:0]    loadBank;
  logic [AW-1:0] loadAddr;
  logic [DW-1:0] loadData;
  logic          loadErr;
  logic          clearReq;
  logic [1:0]    clearBank;
  logic          clearBusy;
  logic          clearDone;
`ifdef PROGMEM_PARITY_EN
  logic          parityErr;
`endif

  always #5 clk = ~clk;

  program_memory_banked #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BANK_DEPTH (BD),
    .NUM_BANKS  (NB),
    .SEL_WIDTH  (SW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .programSelect (programSelect),
    .selLatch      (selLatch),
    .activeBank    (activeBank),
    .bankValid     (bankValid),
    .fetchEn       (fetchEn),
    .address       (address),
    .instruction   (instruction),
    .instrValid    (instrValid),
    .loadValid     (loadValid),
    .loadReady     (loadReady),
    .loadBank      (loadBank),
    .loadAddr      (loadAddr),
    .loadData      (loadData),
    .loadErr       (loadErr),
    .clearReq      (clearReq),
    .clearBank     (clearBank),
    .clearBusy     (clearBusy),
    .clearDone     (clearDone)
`ifdef PROGMEM_PARITY_EN
    ,
    .parityErr     (parityErr)
`endif
  );

  int nCmp = 0;
  int nBad = 0;
  int cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain arrays of words plus the latched selection.
  bit [DW-1:0] mMem   [NB][BD];
  bit          mKnown [NB][BD];
  int          mBank  = 0;
  bit          mValid = 1'b0;

  typedef struct {
    int val;
    int cyc;
    int addr;
  } exp_t;
  exp_t expQ[$];

  task automatic chk(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lowestBit(input logic [SW-1:0] v);
    for (int i = 0; i < SW; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int expFetch(input int a);
    if (!mValid || a >= BD) return 0;
    if (!mKnown[mBank][a]) return -1;
    return int'(mMem[mBank][a]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleIn();
    selLatch  = 1'b0;
    fetchEn   = 1'b0;
    loadValid = 1'b0;
    clearReq  = 1'b0;
  endtask

  // One idle-controller cycle: optional select latch, fetch and load, all issued together.
  task automatic doCycle(input bit sl, input logic [SW-1:0] ps, input bit fe, input int fa,
                         input bit lv, input int lb, input int la, input logic [DW-1:0] ld);
    bit errExp;
    programSelect = ps;
    selLatch      = sl;
    fetchEn       = fe;
    address       = AW'(fa);
    loadValid     = lv;
    loadBank      = 2'(lb);
    loadAddr      = AW'(la);
    loadData      = ld;
    #1;
    if (lv) chk("loadReady", int'(loadReady), 1);
    // Expectation is taken before the model applies this cycle's write/select (read-first, old bank).
    if (fe) expQ.push_back('{val: expFetch(fa), cyc: cyc + 1, addr: fa});
    errExp = lv && (la >= BD);
    if (lv && la < BD) begin
      mMem[lb][la]   = ld;
      mKnown[lb][la] = 1'b1;
    end
    if (sl) begin
      int b = lowestBit(ps);
      if (b >= 0 && b < NB) begin
        mBank  = b;
        mValid = 1'b1;
      end else begin
        mValid = 1'b0;
      end
    end
    tick();
    idleIn();
    chk("loadErr", int'(loadErr), int'(errExp));
    chk("activeBank", int'(activeBank), mBank);
    chk("bankValid", int'(bankValid), int'(mValid));
  endtask

  task automatic fetch(input int a);
    doCycle(1'b0, programSelect, 1'b1, a, 1'b0, 0, 0, '0);
  endtask

  task automatic sel(input logic [SW-1:0] ps);
    doCycle(1'b1, ps, 1'b0, 0, 1'b0, 0, 0, '0);
  endtask

  task automatic load(input int b, input int a, input logic [DW-1:0] d);
    doCycle(1'b0, programSelect, 1'b0, 0, 1'b1, b, a, d);
  endtask

  task automatic runClear(input int bank, input bit withLoad, input int lb, input int la,
                          input logic [DW-1:0] ld);
    int busy = 0;
    int done = 0;
    clearReq  = 1'b1;
    clearBank = 2'(bank);
    loadValid = withLoad;
    loadBank  = 2'(lb);
    loadAddr  = AW'(la);
    loadData  = ld;
    #1;
    chk("loadReadyOnClearReq", int'(loadReady), 0);
    tick();
    clearReq = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (clearBusy) begin
        busy++;
        chk("loadReadyInClear", int'(loadReady), 0);
      end
      if (clearDone) done++;
      if (!clearBusy) break;
      tick();
    end
    for (int a = 0; a < BD; a++) begin
      mMem[bank][a]   = '0;
      mKnown[bank][a] = 1'b1;
    end
    if (withLoad) begin
      chk("loadReadyAfterClear", int'(loadReady), 1);
      mMem[lb][la]   = ld;
      mKnown[lb][la] = 1'b1;
    end
    tick();
    loadValid = 1'b0;
    if (clearDone) done++;
    chk("clearBusyCycles", busy, BD);
    chk("clearDonePulses", done, 1);
    chk("clearBusyAfter", int'(clearBusy), 0);
  endtask

  // Monitor: pops one expectation per presented instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && instrValid) begin
        if (expQ.size() == 0) begin
          chk("unexpectedInstrValid", int'(instrValid), 0);
        end else begin
          e = expQ.pop_front();
          chk("fetchLatency", cyc, e.cyc);
          if (e.val >= 0) chk($sformatf("instr[addr %0d]", e.addr), int'(instruction), e.val);
`ifdef PROGMEM_PARITY_EN
          chk("parityErr", int'(parityErr), 0);
`endif
        end
      end else if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
        chk("instrValidMissing", int'(instrValid), 1);
        e = expQ.pop_front();
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, nCmp=%0d", nCmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] prog [3];
    prog[0] = 16'h1100;
    prog[1] = 16'h0201;
    prog[2] = {HALT_OPCODE, 12'h000};

    rst_n         = 1'b0;
    programSelect = '0;
    address       = '0;
    loadBank      = '0;
    loadAddr      = '0;
    loadData      = '0;
    clearBank     = '0;
    idleIn();
    loadValid = 1'b1;
    #1;
    chk("loadReadyInReset", int'(loadReady), 0);
    loadValid = 1'b0;
    repeat (3) tick();
    chk("rstInstruction", int'(instruction), 0);
    chk("rstInstrValid", int'(instrValid), 0);
    chk("rstActiveBank", int'(activeBank), 0);
    chk("rstBankValid", int'(bankValid), 0);
    chk("rstLoadErr", int'(loadErr), 0);
    chk("rstClearBusy", int'(clearBusy), 0);
    chk("rstClearDone", int'(clearDone), 0);
    rst_n = 1'b1;
    tick();

    // Fill every bank with random words, then place the small program in banks 0 and 1.
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < BD; a++) load(b, a, DW'($urandom));
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 3; a++) load(b, a, prog[a]);

    sel(8'b0000_0011);
    for (int a = 0; a < 3; a++) fetch(a);

    sel(8'b0001_0000);
    for (int a = 0; a < 3; a++) fetch(a);
    sel(8'b0000_0000);
    fetch(0);
    fetch(1);

    // Switches move without selLatch during a fetch stream.
    sel(8'b0000_0010);
    for (int i = 0; i < 16; i++)
      doCycle(1'b0, SW'($urandom), 1'b1, $urandom_range(0, BD - 1), 1'b0, 0, 0, '0);

    // Same-cycle load and fetch of one word: old data first, new data next.
    sel(8'b0000_0001);
    doCycle(1'b0, programSelect, 1'b1, 3, 1'b1, 0, 3, 16'h4332);
    fetch(3);

    // Out-of-range load would alias into bank 1 if not dropped.
    load(0, 200, 16'hDEAD);
    load(2, 7, 16'h0777);
    fetch(200);
    sel(8'b0000_0010);
    fetch(72);

    // Randomized mix of selects, fetches and loads.
    for (int i = 0; i < 400; i++) begin
      bit sl = ($urandom_range(0, 7) == 0);
      bit fe = ($urandom_range(0, 3) != 0);
      bit lv = ($urandom_range(0, 2) == 0);
      int fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(BD, 255)) : int'($urandom_range(0, BD - 1));
      int la = ($urandom_range(0, 7) == 0) ? int'($urandom_range(BD, 255)) : int'($urandom_range(0, BD - 1));
      doCycle(sl, SW'($urandom), fe, fa, lv, $urandom_range(0, NB - 1), la, DW'($urandom));
    end

    // Clear bank 1 with a competing load that must be retried afterwards.
    tick();
    runClear(1, 1'b1, 1, 5, 16'hABCD);
    sel(8'b0000_0010);
    for (int a = 0; a < BD; a++) fetch(a);

    // Reset in the middle of clearing bank 2.
    clearReq  = 1'b1;
    clearBank = 2'd2;
    tick();
    clearReq = 1'b0;
    repeat (50) tick();
    chk("clearBusyMid", int'(clearBusy), 1);
    rst_n = 1'b0;
    #1;
    chk("midRstInstruction", int'(instruction), 0);
    chk("midRstInstrValid", int'(instrValid), 0);
    chk("midRstActiveBank", int'(activeBank), 0);
    chk("midRstBankValid", int'(bankValid), 0);
    chk("midRstClearBusy", int'(clearBusy), 0);
    chk("midRstClearDone", int'(clearDone), 0);
    chk("midRstLoadReady", int'(loadReady), 0);
    for (int a = 0; a < 50; a++) begin
      mMem[2][a]   = '0;
      mKnown[2][a] = 1'b1;
    end
    mBank  = 0;
    mValid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    sel(8'b0000_0100);
    for (int a = 0; a < BD; a++) fetch(a);

    repeat (3) tick();
    chk("queueDrained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
